topo_game_ctrl: RTL and testbench

TOPO_GAME_CTRL -- requirements
Module: topo_game_ctrl

---
 rtl/topo_game_ctrl_if.sv | 41 ++++
 rtl/topo_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_topo_game_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/topo_game_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | topo_game_ctrl_if : board/button handshake bundle for the mole game  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface topo_game_ctrl_if;
  logic       START;
  logic       HIT;
  logic [3:0] N_CELDA_PONER_TOPO;
  logic       PONER_TOPO;
  logic       CLR_BOARD;
  logic [7:0] SCORE;
  logic [3:0] MISSES;
  logic       GAME_OVER;
  logic [2:0] STATE;

  modport master (
    output START,
    output HIT,
    input  N_CELDA_PONER_TOPO,
    input  PONER_TOPO,
    input  CLR_BOARD,
    input  SCORE,
    input  MISSES,
    input  GAME_OVER,
    input  STATE
  );

  modport slave (
    input  START,
    input  HIT,
    output N_CELDA_PONER_TOPO,
    output PONER_TOPO,
    output CLR_BOARD,
    output SCORE,
    output MISSES,
    output GAME_OVER,
    output STATE
  );
endinterface
`default_nettype wire

// File: rtl/topo_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | topo_game_ctrl : whack-a-mole game sequencer for a 4x4 board         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module topo_game_ctrl #(
  parameter logic [31:0] WINDOW_TICKS = 32'd50_000_000,
  parameter logic [31:0] GAP_TICKS    = 32'd12_500_000,
  parameter logic [3:0]  MAX_MISSES   = 4'd3,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  wire              CLK,
  input  wire              reset,
  topo_game_ctrl_if.slave  io_game
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SPAWN    = 3'd1,
    S_WAIT_HIT = 3'd2,
    S_SCORED   = 3'd3,
    S_MISSED   = 3'd4,
    S_GAP      = 3'd5,
    S_OVER     = 3'd6
  } state_t;

  state_t      r_state;
  logic [31:0] r_timer;
  logic [7:0]  r_lfsr;
  logic [3:0]  r_cell;
  logic        r_poner;
  logic        r_clr;
  logic [7:0]  r_score;
  logic [3:0]  r_misses;
  logic        r_start_d;
  logic        r_hit_d;

  state_t      w_state_nxt;
  logic [31:0] w_timer_nxt;
  logic [3:0]  w_cell_nxt;
  logic        w_poner_nxt;
  logic        w_clr_nxt;
  logic [7:0]  w_score_nxt;
  logic [3:0]  w_misses_nxt;
  logic        w_start_edge;
  logic        w_hit_edge;
  logic        w_restart;
  logic        w_lfsr_fb;
  logic [7:0]  w_lfsr_nxt;
  logic [3:0]  w_cand;
  logic [3:0]  w_cell_pick;

  assign w_start_edge = io_game.START & ~r_start_d;
  assign w_hit_edge   = io_game.HIT & ~r_hit_d;
  assign w_restart    = w_start_edge &&
                        (r_state inside {S_IDLE, S_SPAWN, S_WAIT_HIT, S_SCORED,
                                         S_MISSED, S_GAP, S_OVER});

  // x^8+x^6+x^5+x^4+1, shifting left; an all-zero register is recovered by reloading the seed
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_lfsr_nxt = (r_lfsr == 8'd0) ? LFSR_SEED : {r_lfsr[6:0], w_lfsr_fb};

  // Never place the mole twice in a row on the same cell
  assign w_cand      = r_lfsr[3:0];
  assign w_cell_pick = (w_cand == r_cell) ? (w_cand + 4'd1) : w_cand;

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_cell_nxt   = r_cell;
    w_poner_nxt  = 1'b0;
    w_clr_nxt    = 1'b0;
    w_score_nxt  = r_score;
    w_misses_nxt = r_misses;

    if (w_restart) begin
      w_score_nxt  = 8'd0;
      w_misses_nxt = 4'd0;
      w_clr_nxt    = 1'b1;
      w_state_nxt  = S_SPAWN;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_SPAWN: begin
          w_cell_nxt  = w_cell_pick;
          w_poner_nxt = 1'b1;
          w_timer_nxt = WINDOW_TICKS - 32'd1;
          w_state_nxt = S_WAIT_HIT;
        end
        S_WAIT_HIT: begin
          if (w_hit_edge) begin
            w_score_nxt = (r_score == 8'hFF) ? 8'hFF : (r_score + 8'd1);
            w_clr_nxt   = 1'b1;
            w_state_nxt = S_SCORED;
          end else if (r_timer == 32'd0) begin
            w_misses_nxt = r_misses + 4'd1;
            w_clr_nxt    = 1'b1;
            w_state_nxt  = S_MISSED;
          end else begin
            w_timer_nxt = r_timer - 32'd1;
          end
        end
        S_SCORED: begin
          w_timer_nxt = GAP_TICKS - 32'd1;
          w_state_nxt = S_GAP;
        end
        S_MISSED: begin
          // Counter was bumped on entry, so r_misses already holds the new total
          if (r_misses == MAX_MISSES) begin
            w_state_nxt = S_OVER;
          end else begin
            w_timer_nxt = GAP_TICKS - 32'd1;
            w_state_nxt = S_GAP;
          end
        end
        S_GAP: begin
          if (r_timer == 32'd0) begin
            w_state_nxt = S_SPAWN;
          end else begin
            w_timer_nxt = r_timer - 32'd1;
          end
        end
        S_OVER: begin
          w_state_nxt = S_OVER;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_timer   <= 32'd0;
      r_lfsr    <= LFSR_SEED;
      r_cell    <= 4'd0;
      r_poner   <= 1'b0;
      r_clr     <= 1'b0;
      r_score   <= 8'd0;
      r_misses  <= 4'd0;
      r_start_d <= 1'b0;
      r_hit_d   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_cell    <= w_cell_nxt;
      r_poner   <= w_poner_nxt;
      r_clr     <= w_clr_nxt;
      r_score   <= w_score_nxt;
      r_misses  <= w_misses_nxt;
      r_start_d <= io_game.START;
      r_hit_d   <= io_game.HIT;
    end
  end

  assign io_game.N_CELDA_PONER_TOPO = r_cell;
  assign io_game.PONER_TOPO         = r_poner;
  assign io_game.CLR_BOARD          = r_clr;
  assign io_game.SCORE              = r_score;
  assign io_game.MISSES             = r_misses;
  assign io_game.GAME_OVER          = (r_state == S_OVER);
  assign io_game.STATE              = r_state;

endmodule
`default_nettype wire

// File: tb/tb_topo_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_topo_game_ctrl : directed bench for the mole game sequencer       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_topo_game_ctrl;
  localparam logic [7:0] C_SEED = 8'hA5;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  topo_game_ctrl_if bus ();

  topo_game_ctrl #(
    .WINDOW_TICKS (32'd4),
    .GAP_TICKS    (32'd2),
    .MAX_MISSES   (4'd3),
    .LFSR_SEED    (C_SEED)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .io_game (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    if (v == 8'd0) return C_SEED;
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR: m_lfsr is the value during the current cycle, m_lfsr_d the previous one
  logic [7:0] m_lfsr, m_lfsr_d;
  always @(posedge CLK or posedge reset) begin
    if (reset) begin
      m_lfsr   <= C_SEED;
      m_lfsr_d <= C_SEED;
    end else begin
      m_lfsr_d <= m_lfsr;
      m_lfsr   <= lfsr_step(m_lfsr);
    end
  end

  logic [3:0] prev_model = 4'd0;
  logic [3:0] exp_cell;
  bit         wrap_seen = 1'b0;

  // Placement scoreboard, sampled 1 time unit after each rising edge
  always begin
    @(posedge CLK);
    #1;
    if (reset) begin
      prev_model = 4'd0;
    end else begin
      if (bus.PONER_TOPO === 1'b1) begin
        exp_cell = (m_lfsr_d[3:0] == prev_model) ? prev_model + 4'd1 : m_lfsr_d[3:0];
        if (m_lfsr_d[3:0] == prev_model && prev_model == 4'hF) wrap_seen = 1'b1;
        prev_model = exp_cell;
      end
      tests++;
      if (bus.N_CELDA_PONER_TOPO !== prev_model) begin
        fails++;
        $display("FAIL cell: got %0d expected %0d at %0t", bus.N_CELDA_PONER_TOPO, prev_model, $time);
      end
      if (bus.PONER_TOPO === 1'b1 || bus.CLR_BOARD === 1'b1) begin
        tests++;
        if (bus.PONER_TOPO === 1'b1 && bus.CLR_BOARD === 1'b1) begin
          fails++;
          $display("FAIL strobe_overlap: PONER_TOPO and CLR_BOARD both 1 at %0t", $time);
        end
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_start;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tick();
  endtask

  // From the PONER cycle: hit immediately, come back at the next PONER cycle
  task automatic quick_hit;
    bus.HIT = 1'b1;
    tick();
    bus.HIT = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    bus.START = 1'b0;
    bus.HIT   = 1'b0;
    reset     = 1'b1;
    repeat (2) tick();
    tests++;
    if ({bus.STATE, bus.PONER_TOPO, bus.CLR_BOARD, bus.SCORE, bus.MISSES, bus.GAME_OVER, bus.N_CELDA_PONER_TOPO} !== 23'd0) begin
      fails++;
      $display("FAIL reset_values: state=%0d poner=%0b clr=%0b score=%0d misses=%0d over=%0b cell=%0d, required all 0",
               bus.STATE, bus.PONER_TOPO, bus.CLR_BOARD, bus.SCORE, bus.MISSES, bus.GAME_OVER, bus.N_CELDA_PONER_TOPO);
    end
    reset = 1'b0;
    repeat (3) tick();
    tests++;
    if (bus.STATE !== 3'd0) begin
      fails++;
      $display("FAIL idle_without_start: state=%0d expected 0", bus.STATE);
    end
  endtask

  task automatic test_start;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tests++;
    if (bus.STATE !== 3'd1 || bus.CLR_BOARD !== 1'b1 || bus.PONER_TOPO !== 1'b0) begin
      fails++;
      $display("FAIL start_spawn: state=%0d clr=%0b poner=%0b expected 1/1/0", bus.STATE, bus.CLR_BOARD, bus.PONER_TOPO);
    end
    tick();
    tests++;
    if (bus.STATE !== 3'd2 || bus.CLR_BOARD !== 1'b0 || bus.PONER_TOPO !== 1'b1) begin
      fails++;
      $display("FAIL start_place: state=%0d clr=%0b poner=%0b expected 2/0/1", bus.STATE, bus.CLR_BOARD, bus.PONER_TOPO);
    end
  endtask

  task automatic test_hit;
    tick();
    tick();
    bus.HIT = 1'b1;
    tick();
    bus.HIT = 1'b0;
    tests++;
    if (bus.STATE !== 3'd3 || bus.CLR_BOARD !== 1'b1 || bus.SCORE !== 8'd1) begin
      fails++;
      $display("FAIL hit_scored: state=%0d clr=%0b score=%0d expected 3/1/1", bus.STATE, bus.CLR_BOARD, bus.SCORE);
    end
    tick();
    tick();
    tests++;
    if (bus.STATE !== 3'd5 || bus.CLR_BOARD !== 1'b0) begin
      fails++;
      $display("FAIL hit_gap: state=%0d clr=%0b expected 5/0", bus.STATE, bus.CLR_BOARD);
    end
    tick();
    tick();
    tests++;
    if (bus.STATE !== 3'd2 || bus.PONER_TOPO !== 1'b1 || bus.SCORE !== 8'd1) begin
      fails++;
      $display("FAIL hit_next_place: state=%0d poner=%0b score=%0d expected 2/1/1", bus.STATE, bus.PONER_TOPO, bus.SCORE);
    end
  endtask

  task automatic test_miss;
    do_start();
    quick_hit();
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick();
      tests++;
      if (bus.STATE !== 3'd2) begin
        fails++;
        $display("FAIL miss_window_%0d: state=%0d expected 2", i, bus.STATE);
      end
      tick();
      tests++;
      if (bus.STATE !== 3'd4 || bus.MISSES !== 4'(i + 1) || bus.CLR_BOARD !== 1'b1) begin
        fails++;
        $display("FAIL miss_%0d: state=%0d misses=%0d clr=%0b expected 4/%0d/1", i, bus.STATE, bus.MISSES, bus.CLR_BOARD, i + 1);
      end
      if (i < 2) begin
        repeat (3) tick();
        tick();
      end
    end
    tick();
    tests++;
    if (bus.STATE !== 3'd6 || bus.GAME_OVER !== 1'b1 || bus.SCORE !== 8'd1 || bus.MISSES !== 4'd3) begin
      fails++;
      $display("FAIL game_over: state=%0d over=%0b score=%0d misses=%0d expected 6/1/1/3",
               bus.STATE, bus.GAME_OVER, bus.SCORE, bus.MISSES);
    end
    repeat (2) begin
      bus.HIT = 1'b1;
      tick();
      bus.HIT = 1'b0;
      tick();
    end
    tests++;
    if (bus.STATE !== 3'd6 || bus.SCORE !== 8'd1 || bus.MISSES !== 4'd3) begin
      fails++;
      $display("FAIL over_hold: state=%0d score=%0d misses=%0d expected 6/1/3", bus.STATE, bus.SCORE, bus.MISSES);
    end
  endtask

  task automatic test_hit_at_zero;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tests++;
    if (bus.STATE !== 3'd1 || bus.CLR_BOARD !== 1'b1 || bus.SCORE !== 8'd0 || bus.MISSES !== 4'd0 || bus.GAME_OVER !== 1'b0) begin
      fails++;
      $display("FAIL restart_from_over: state=%0d clr=%0b score=%0d misses=%0d over=%0b expected 1/1/0/0/0",
               bus.STATE, bus.CLR_BOARD, bus.SCORE, bus.MISSES, bus.GAME_OVER);
    end
    tick();
    repeat (3) tick();
    bus.HIT = 1'b1;
    tick();
    bus.HIT = 1'b0;
    tests++;
    if (bus.STATE !== 3'd3 || bus.MISSES !== 4'd0 || bus.SCORE !== 8'd1) begin
      fails++;
      $display("FAIL hit_at_zero: state=%0d misses=%0d score=%0d expected 3/0/1", bus.STATE, bus.MISSES, bus.SCORE);
    end
    repeat (4) tick();
  endtask

  task automatic test_saturate_abort;
    do_start();
    repeat (256) quick_hit();
    tests++;
    if (bus.SCORE !== 8'd255 || bus.STATE !== 3'd2) begin
      fails++;
      $display("FAIL score_saturate: score=%0d state=%0d expected 255/2", bus.SCORE, bus.STATE);
    end
    bus.HIT = 1'b1;
    tick();
    bus.HIT = 1'b0;
    tick();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    tests++;
    if (bus.STATE !== 3'd1 || bus.CLR_BOARD !== 1'b1 || bus.SCORE !== 8'd0) begin
      fails++;
      $display("FAIL abort_in_gap: state=%0d clr=%0b score=%0d expected 1/1/0", bus.STATE, bus.CLR_BOARD, bus.SCORE);
    end
    tick();
  endtask

  task automatic test_reset_midgame;
    repeat (5) quick_hit();
    tick();
    tests++;
    if (bus.STATE !== 3'd2 || bus.SCORE !== 8'd5) begin
      fails++;
      $display("FAIL pre_reset: state=%0d score=%0d expected 2/5", bus.STATE, bus.SCORE);
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.STATE, bus.PONER_TOPO, bus.CLR_BOARD, bus.SCORE, bus.MISSES, bus.GAME_OVER, bus.N_CELDA_PONER_TOPO} !== 23'd0) begin
      fails++;
      $display("FAIL async_reset: state=%0d poner=%0b clr=%0b score=%0d misses=%0d over=%0b cell=%0d, required all 0",
               bus.STATE, bus.PONER_TOPO, bus.CLR_BOARD, bus.SCORE, bus.MISSES, bus.GAME_OVER, bus.N_CELDA_PONER_TOPO);
    end
    bus.HIT = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    tests++;
    if (bus.STATE !== 3'd0 || bus.SCORE !== 8'd0) begin
      fails++;
      $display("FAIL post_reset_idle: state=%0d score=%0d expected 0/0", bus.STATE, bus.SCORE);
    end
    do_start();
    repeat (4) tick();
    tests++;
    if (bus.STATE !== 3'd4 || bus.SCORE !== 8'd0 || bus.MISSES !== 4'd1) begin
      fails++;
      $display("FAIL held_hit_ignored: state=%0d score=%0d misses=%0d expected 4/0/1", bus.STATE, bus.SCORE, bus.MISSES);
    end
    bus.HIT = 1'b0;
    tick();
  endtask

  // Restart exactly when the next SPAWN candidate equals the current target
  task automatic test_collision;
    logic [7:0] nx;
    for (int cyc = 0; cyc < 6000 && !wrap_seen; cyc++) begin
      nx = lfsr_step(m_lfsr);
      if (bus.START) bus.START = 1'b0;
      else if (nx[3:0] == prev_model) bus.START = 1'b1;
      tick();
    end
    bus.START = 1'b0;
    repeat (3) tick();
    tests++;
    if (!wrap_seen) begin
      fails++;
      $display("FAIL collision_wrap: no 15->0 collision placement observed within budget");
    end
  endtask

  initial begin
    bus.START = 1'b0;
    bus.HIT   = 1'b0;
    test_reset();
    test_start();
    test_hit();
    test_miss();
    test_hit_at_zero();
    test_saturate_abort();
    test_reset_midgame();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
